instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Front-end stage that sits directly upstream of the Decoder and drives the instruction-side read port of Main_Memory. It holds the 13-bit PC and issues read requests. It waits on the memory done handshake, then presents one registered instruction word with a valid/ready handshake to the decode stage. It accepts branch redirects (BEQ target / newPC) from the datapath and discards any stale in-flight fetch.

Parameters:
ADDR_W, 13, PC / memory address width
DATA_W, 13, instruction word width
RESET_PC, 13'd0, PC value loaded on reset
TIMEOUT, 15, max cycles in WAIT without mem_done before fault (4-bit counter)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
halt  in  1  1 = do not start new fetches; in-flight fetch completes
mem_read  out  1  instruction read request to Main_Memory
mem_addr  out  ADDR_W  fetch address (current PC)
mem_data  in  DATA_W  instruction word from Main_Memory
mem_done  in  1  memory completion strobe, 1 cycle
branch_taken  in  1  redirect pulse (BEQ taken / jump)
branch_target  in  ADDR_W  new PC, sampled when branch_taken=1
instr_valid  out  1  instr_word/instr_pc valid for decode
instr_ready  in  1  decode accepts the word this cycle
instr_word  out  DATA_W  fetched instruction
instr_pc  out  ADDR_W  address instr_word came from
fetch_err  out  1  sticky memory timeout fault

Behaviour:
- Reset (reset=0, async): state=IDLE, pc=RESET_PC, mem_read=0, mem_addr=RESET_PC, instr_valid=0, instr_word=0, instr_pc=0, fetch_err=0, discard=0, tcount=0.
- States: IDLE, REQ, WAIT, VALID, ERR.
- IDLE: if halt=0, go to REQ next cycle.
- REQ (1 cycle): mem_read=1, mem_addr=pc, tcount=0. Go to WAIT.
- WAIT:
  - mem_read held 1 and mem_addr held stable until mem_done.
  - tcount increments each cycle.
  - On mem_done with discard=0: instr_word<=mem_data, instr_pc<=pc, pc<=pc+1, instr_valid<=1, go to VALID.
  - PC increment is modulo 2^ADDR_W; 8191+1 wraps to 0.
  - On mem_done with discard=1: drop the data, clear discard, go to REQ (halt=0) or IDLE (halt=1).
- Latency: instr_valid rises the cycle after mem_done. With 1-cycle memory, reset release to first valid is 3 cycles.
- VALID:
  - instr_valid=1; instr_word and instr_pc are stable until handshake.
  - On instr_valid and instr_ready: instr_valid<=0, then go to REQ (halt=0) or IDLE (halt=1).
  - No prefetch: at most one outstanding fetch, one buffered word.
- Redirect (branch_taken=1): pc<=branch_target in any non-ERR state.
  - IDLE/REQ: next fetch uses the new pc. A REQ-cycle redirect sets discard=1, since the request already issued.
  - WAIT: discard<=1; the new target is fetched after the old mem_done.
  - VALID: instr_valid<=0 next cycle, word dropped, go to REQ.
- Simultaneous redirect and handshake in VALID: redirect wins; the word counts as consumed, next fetch is from branch_target.
- Simultaneous mem_done and branch_taken in WAIT: data dropped, pc=branch_target, go to REQ.
- Timeout: in WAIT, when tcount reaches TIMEOUT without mem_done:
  - fetch_err<=1, mem_read<=0, go to ERR.
  - ERR is terminal; outputs are held and fetch_err is cleared only by reset.
- Reset mid-operation: immediate return to reset values. A late mem_done after reset release is ignored in IDLE.

Decomposition:
- Shared cpu package:
  - ADDR_W / DATA_W constants
  - fetch state encoding (IDLE=0, REQ=1, WAIT=2, VALID=3, ERR=4, 3-bit)
  - RESET_PC
  - opcode field position (bits [12:10]), shared with Decoder
- One optional sub-module, fetch_timeout_ctr: the 4-bit WAIT counter with clear/enable and an expiry output. Everything else stays in one FSM module.

Test Plan:
- Reset release, 2-cycle memory returning 13'h0A3 at addr 0, instr_ready=1 -> mem_read rises cycle 1; instr_valid=1 with instr_word=13'h0A3, instr_pc=0; next mem_addr=1.
- instr_ready=0 for 5 cycles in VALID -> instr_valid, instr_word and instr_pc stable; mem_read stays 0; fetch resumes the cycle after ready=1.
- branch_taken with target 13'h0100 during WAIT at addr 4 -> mem_done data for addr 4 never appears on instr_valid; next mem_addr=13'h0100, instr_pc=13'h0100.
- pc=13'h1FFF fetched and consumed -> next mem_addr=0.
- Same cycle: instr_ready=1 and branch_taken with target 13'h0020 in VALID -> next fetch at 13'h0020, not pc+1.
- mem_done withheld for 15 cycles -> fetch_err=1, mem_read=0, state ERR. Later mem_done is ignored; reset=0 clears fetch_err to 0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU constants: bus widths, reset PC, fetch FSM encoding and the
// opcode field location that the Decoder also relies on.
package instr_fetch_unit_pkg;

    localparam int CPU_ADDR_W  = 13;
    localparam int CPU_DATA_W  = 13;
    localparam int CPU_TIMEOUT = 15;

    localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = 13'd0;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_VALID = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    localparam int OPC_MSB = 12;
    localparam int OPC_LSB = 10;

    typedef logic [CPU_ADDR_W-1:0] addr_t;
    typedef logic [CPU_DATA_W-1:0] word_t;

    function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input word_t w);
        return w[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_timeout_ctr.sv
// 4-bit up-counter measuring how long a fetch has waited on memory;
// expire_o fires on the cycle the LIMIT-th enabled count is reached.
module fetch_timeout_ctr #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [3:0] LAST = 4'(LIMIT - 1);

    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 4'd0;
        end else if (en_i) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = en_i && (count_q == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: one outstanding memory read, one buffered
// word towards decode, branch redirects with stale-fetch discard.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC),
    parameter int TIMEOUT = CPU_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_done,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_word,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              fetch_err
);

    // state | meaning
    // IDLE  | no fetch in progress, waiting for halt=0
    // REQ   | read issued at pc, address captured
    // WAIT  | read outstanding, waiting for mem_done or timeout
    // VALID | word buffered, waiting for decode handshake
    // ERR   | memory timed out, frozen until reset

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [DATA_W-1:0] instr_word_q, instr_word_d;
    logic              instr_valid_q, instr_valid_d;
    logic              discard_q, discard_d;
    logic              fetch_err_q, fetch_err_d;
    logic              tmr_clr, tmr_en, tmr_expire;

    fetch_timeout_ctr #(.LIMIT(TIMEOUT)) u_timeout (
        .clk      (clk),
        .rst_n    (reset),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expire_o (tmr_expire)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_addr_d  = fetch_addr_q;
        instr_pc_d    = instr_pc_q;
        instr_word_d  = instr_word_q;
        instr_valid_d = instr_valid_q;
        discard_d     = discard_q;
        fetch_err_d   = fetch_err_q;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;

        if (branch_taken && (state_q != ST_ERR)) begin
            pc_d = branch_target;
        end

        case (state_q)
            ST_IDLE: begin
                if (!halt) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                fetch_addr_d = pc_q;
                tmr_clr      = 1'b1;
                state_d      = ST_WAIT;
                // the read at the old pc is already on the bus
                if (branch_taken) begin
                    discard_d = 1'b1;
                end
            end
            ST_WAIT: begin
                tmr_en = 1'b1;
                if (mem_done) begin
                    if (discard_q || branch_taken) begin
                        discard_d = 1'b0;
                        state_d   = halt ? ST_IDLE : ST_REQ;
                    end else begin
                        instr_word_d  = mem_data;
                        instr_pc_d    = fetch_addr_q;
                        pc_d          = pc_q + ADDR_W'(1);
                        instr_valid_d = 1'b1;
                        state_d       = ST_VALID;
                    end
                end else if (tmr_expire) begin
                    fetch_err_d = 1'b1;
                    state_d     = ST_ERR;
                end else if (branch_taken) begin
                    discard_d = 1'b1;
                end
            end
            ST_VALID: begin
                // a redirect drops the buffered word even if decode takes it
                if (branch_taken || instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = halt ? ST_IDLE : ST_REQ;
                end
            end
            ST_ERR: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            fetch_addr_q  <= RESET_PC;
            instr_pc_q    <= '0;
            instr_word_q  <= '0;
            instr_valid_q <= 1'b0;
            discard_q     <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_addr_q  <= fetch_addr_d;
            instr_pc_q    <= instr_pc_d;
            instr_word_q  <= instr_word_d;
            instr_valid_q <= instr_valid_d;
            discard_q     <= discard_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    // pc may be redirected mid-read, so the bus shows the captured address
    assign mem_read    = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign mem_addr    = ((state_q == ST_WAIT) || (state_q == ST_ERR)) ? fetch_addr_q : pc_q;
    assign instr_valid = instr_valid_q;
    assign instr_word  = instr_word_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_err   = fetch_err_q;

endmodule
